// File: rtl/prbs_2tap_chk.sv
// Serial checker for the 2-tap XNOR LFSR stream: self-syncs a shadow LFSR, locks, then flywheels and counts errors.
// Optional macro PRBS_CHK_BITCNT_EN adds a saturating BIT_CNT of bits compared while locked.
module prbs_2tap_chk #(
  parameter int N            = 3,
  parameter int FB_tap       = 2,
  parameter int LOCK_MATCHES = 16,
  parameter int LOSS_WINDOW  = 64,
  parameter int LOSS_THRESH  = 4,
  parameter int ERR_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIN,
  input  logic             CLR_ERR,
  output logic             LOCKED,
  output logic [1:0]       STATE,
  output logic             ERR_STB,
`ifdef PRBS_CHK_BITCNT_EN
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [31:0]      BIT_CNT
`else
  output logic [ERR_W-1:0] ERR_CNT
`endif
);

  localparam int FW  = $clog2(N + 1);
  localparam int MW  = $clog2(LOCK_MATCHES + 1);
  localparam int WW  = $clog2(LOSS_WINDOW + 1);
  localparam int WEW = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCK   = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [N:1]       sh_q, sh_d;
  logic [FW-1:0]    fill_cnt_q, fill_cnt_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [WW-1:0]    win_cnt_q, win_cnt_d;
  logic [WEW-1:0]   win_err_q, win_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;
  logic             err_stb_q, err_stb_d;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0]      bit_cnt_q, bit_cnt_d;
`endif

  logic             pred;
  logic             din_err;
  logic             sh_ones;
  logic [WEW-1:0]   win_err_nxt;

  always_comb begin
    pred        = ~(sh_q[N] ^ sh_q[FB_tap]);
    din_err     = DIN ^ pred;
    sh_ones     = &sh_q;
    win_err_nxt = win_err_q + WEW'(din_err);

    state_d     = state_q;
    sh_d        = sh_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q;
    locked_d    = locked_q;
    err_stb_d   = 1'b0;
`ifdef PRBS_CHK_BITCNT_EN
    bit_cnt_d   = bit_cnt_q;
`endif

    if (EN) begin
      if (CLR_ERR) begin
        err_cnt_d = '0;
`ifdef PRBS_CHK_BITCNT_EN
        bit_cnt_d = '0;
`endif
      end

      case (state_q)
        ST_FILL: begin
          sh_d = {sh_q[N-1:1], DIN};
          if (fill_cnt_q == FW'(N - 1)) begin
            state_d     = ST_VERIFY;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end

        ST_VERIFY: begin
          sh_d = {sh_q[N-1:1], DIN};
          // All-ones is the XNOR lockup state; a match there proves nothing.
          if (!din_err && !sh_ones) begin
            if (match_cnt_q == MW'(LOCK_MATCHES - 1)) begin
              state_d     = ST_LOCK;
              locked_d    = 1'b1;
              match_cnt_d = '0;
              win_cnt_d   = '0;
              win_err_d   = '0;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            match_cnt_d = '0;
          end
        end

        ST_LOCK: begin
          // Flywheel on the prediction so a corrupted bit is never fed back.
          sh_d = {sh_q[N-1:1], pred};
`ifdef PRBS_CHK_BITCNT_EN
          if (!CLR_ERR && !(&bit_cnt_q)) bit_cnt_d = bit_cnt_q + 1'b1;
`endif
          if (din_err) begin
            err_stb_d = 1'b1;
            if (!CLR_ERR && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
          end
          if (win_err_nxt == WEW'(LOSS_THRESH)) begin
            state_d    = ST_FILL;
            locked_d   = 1'b0;
            fill_cnt_d = '0;
          end
          if (win_cnt_q == WW'(LOSS_WINDOW - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_nxt;
          end
        end

        default: begin
          state_d  = ST_FILL;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_FILL;
      sh_q        <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_stb_q   <= 1'b0;
`ifdef PRBS_CHK_BITCNT_EN
      bit_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      err_stb_q   <= err_stb_d;
`ifdef PRBS_CHK_BITCNT_EN
      bit_cnt_q   <= bit_cnt_d;
`endif
    end
  end

  assign LOCKED  = locked_q;
  assign STATE   = state_q;
  assign ERR_STB = err_stb_q;
  assign ERR_CNT = err_cnt_q;
`ifdef PRBS_CHK_BITCNT_EN
  assign BIT_CNT = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs_2tap_chk.sv
// Bench for prbs_2tap_chk: fixed lock/error table, hand-written corner sequences,
// and randomized traffic checked every cycle against a queue-based reference model.
module tb_prbs_2tap_chk;
  localparam int N       = 3;
  localparam int FB      = 2;
  localparam int LM      = 16;
  localparam int LW      = 64;
  localparam int LT      = 4;
  localparam int EW      = 4;
  localparam int ERR_MAX = (1 << EW) - 1;
  localparam longint BMAX = 64'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst, en, din, clr;
  logic          locked, err_stb;
  logic [1:0]    state;
  logic [EW-1:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0]   bit_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prbs_2tap_chk #(
    .N(N), .FB_tap(FB), .LOCK_MATCHES(LM), .LOSS_WINDOW(LW), .LOSS_THRESH(LT), .ERR_W(EW)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en), .DIN(din), .CLR_ERR(clr),
    .LOCKED(locked), .STATE(state), .ERR_STB(err_stb),
`ifdef PRBS_CHK_BITCNT_EN
    .ERR_CNT(err_cnt), .BIT_CNT(bit_cnt)
`else
    .ERR_CNT(err_cnt)
`endif
  );

  // Reference model: hist holds the last N reference bits, oldest first.
  int     m_state, m_fill, m_match, m_win, m_werr, m_err;
  longint m_bits;
  bit     m_stb;
  bit     hist[$];
  logic [N:1] g;

  function automatic void m_reset();
    m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_err = 0;
    m_bits = 0; m_stb = 1'b0;
    hist.delete();
    for (int i = 0; i < N; i++) hist.push_back(1'b0);
  endfunction

  function automatic void m_step(bit e, bit d, bit c);
    bit pred, ones, err;
    m_stb = 1'b0;
    if (!e) return;
    pred = !(hist[0] ^ hist[N-FB]);
    ones = 1'b1;
    foreach (hist[i]) if (!hist[i]) ones = 1'b0;
    if (c) begin m_err = 0; m_bits = 0; end
    void'(hist.pop_front());
    case (m_state)
      0: begin
        hist.push_back(d);
        m_fill++;
        if (m_fill == N) begin m_state = 1; m_fill = 0; m_match = 0; end
      end
      1: begin
        hist.push_back(d);
        if (d == pred && !ones) m_match++; else m_match = 0;
        if (m_match == LM) begin m_state = 2; m_match = 0; m_win = 0; m_werr = 0; end
      end
      default: begin
        err = (d != pred);
        hist.push_back(pred);
        m_stb = err;
        if (!c) begin
          if (m_bits < BMAX) m_bits++;
          if (err && m_err < ERR_MAX) m_err++;
        end
        m_win++;
        if (err) m_werr++;
        if (m_werr == LT) begin m_state = 0; m_fill = 0; end
        else if (m_win == LW) begin m_win = 0; m_werr = 0; end
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit e, input bit d, input bit c);
    @(negedge clk);
    en = e; din = d; clr = c;
    m_step(e, d, c);
    @(posedge clk);
    #1;
    chk("state", 64'(state), 64'(m_state));
    chk("locked", 64'(locked), 64'(m_state == 2));
    chk("err_stb", 64'(err_stb), 64'(m_stb));
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
`ifdef PRBS_CHK_BITCNT_EN
    chk("bit_cnt", 64'(bit_cnt), 64'(m_bits));
`endif
  endtask

  // Next generator bit (optionally corrupted); EN=0 cycles carry junk and do not advance it.
  task automatic gbit(input bit e, input bit flip, input bit c);
    bit b;
    if (e) begin
      b = ~(g[N] ^ g[FB]);
      g = {g[N-1:1], b};
      b = b ^ flip;
    end else begin
      b = 1'($urandom_range(0, 1));
    end
    cyc(e, b, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
    m_reset();
    g = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lock_up();
    do_reset();
    repeat (N + LM) gbit(1'b1, 1'b0, 1'b0);
    chk("lock_after_19", 64'(locked), 64'd1);
  endtask

  typedef struct {
    bit en, din, clr;
    int st;
    bit lk, stb;
    int cnt;
  } vec_t;

  vec_t tbl[24];
  bit   pat[7];
  bit   seen_lock;
  logic [1:0] prev_state;

  initial begin
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 24; i++) begin
      tbl[i].en  = 1'b1;
      tbl[i].clr = 1'b0;
      tbl[i].din = pat[i % 7] ^ (i == 20);
      tbl[i].st  = (i < 2) ? 0 : (i < 18) ? 1 : 2;
      tbl[i].lk  = (i >= 18);
      tbl[i].stb = (i == 20);
      tbl[i].cnt = (i >= 20) ? 1 : 0;
    end

    rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
    m_reset();
    g = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_err_stb", 64'(err_stb), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;

    // Lock from reset, then a single inverted bit two bits after lock.
    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].en, tbl[i].din, tbl[i].clr);
      chk($sformatf("tbl_state[%0d]", i), 64'(state), 64'(tbl[i].st));
      chk($sformatf("tbl_locked[%0d]", i), 64'(locked), 64'(tbl[i].lk));
      chk($sformatf("tbl_stb[%0d]", i), 64'(err_stb), 64'(tbl[i].stb));
      chk($sformatf("tbl_cnt[%0d]", i), 64'(err_cnt), 64'(tbl[i].cnt));
    end

    // Four errors inside one window force loss of lock on the fourth.
    lock_up();
    for (int k = 0; k <= 30; k++) begin
      gbit(1'b1, (k == 2 || k == 10 || k == 20 || k == 30), 1'b0);
      if (k == 30) begin
        chk("loss_locked", 64'(locked), 64'd0);
        chk("loss_state", 64'(state), 64'd0);
        chk("loss_err_cnt", 64'(err_cnt), 64'd4);
        chk("loss_stb", 64'(err_stb), 64'd1);
      end
    end

    // Three errors per window on either side of a wrap keep lock.
    lock_up();
    for (int k = 0; k < 80; k++)
      gbit(1'b1, (k >= 5 && k <= 7) || (k >= 65 && k <= 67), 1'b0);
    chk("wrap_locked", 64'(locked), 64'd1);
    chk("wrap_err_cnt", 64'(err_cnt), 64'd6);

    // Stuck-at-1 line sits in the lockup state and never locks.
    do_reset();
    seen_lock = 1'b0;
    repeat (200) begin
      cyc(1'b1, 1'b1, 1'b0);
      seen_lock |= locked;
    end
    chk("stuck_never_lock", 64'(seen_lock), 64'd0);

    // EN gating: lock after 19 qualified bits, state frozen on EN=0 cycles.
    do_reset();
    for (int i = 0; i < 38; i++) begin
      prev_state = state;
      gbit((i % 2) == 0, 1'b0, 1'b0);
      if ((i % 2) == 1) chk("en_low_hold", 64'(state), 64'(prev_state));
      if (i == 35) chk("en_not_yet_locked", 64'(locked), 64'd0);
      if (i == 36) chk("en_locked_19", 64'(locked), 64'd1);
    end

    // Saturation across relocks, then clear coincident with an error.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (!locked) repeat (N + LM) gbit(1'b1, 1'b0, 1'b0);
      gbit(1'b1, 1'b1, 1'b0);
      gbit(1'b1, 1'b0, 1'b0);
    end
    chk("sat_err_cnt", 64'(err_cnt), 64'(ERR_MAX));
    if (!locked) repeat (N + LM) gbit(1'b1, 1'b0, 1'b0);
    gbit(1'b1, 1'b1, 1'b1);
    chk("clr_err_cnt", 64'(err_cnt), 64'd0);
    chk("clr_stb", 64'(err_stb), 64'd1);
`ifdef PRBS_CHK_BITCNT_EN
    chk("clr_bit_cnt", 64'(bit_cnt), 64'd0);
`endif

    // Asynchronous reset mid-lock, then relock.
    lock_up();
    gbit(1'b1, 1'b1, 1'b0);
    gbit(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1; en = 1'b0;
    #1;
    chk("arst_locked", 64'(locked), 64'd0);
    chk("arst_state", 64'(state), 64'd0);
    chk("arst_err_cnt", 64'(err_cnt), 64'd0);
    m_reset();
    g = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (N + LM - 1) gbit(1'b1, 1'b0, 1'b0);
    chk("arst_relock_18", 64'(locked), 64'd0);
    gbit(1'b1, 1'b0, 1'b0);
    chk("arst_relock_19", 64'(locked), 64'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        repeat (30) cyc(1'b1, 1'b1, 1'b0);
      end else begin
        gbit($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
